// File: rtl/gf_mul_iter.sv
// Iterative GF(2^WIDTH) multiplier: LSB-first shift-and-add on b with xtime
// reduction by POLY, STEPS_PER_CYCLE steps per clock, valid/ready handshakes.
module gf_mul_iter #(
    parameter int unsigned           WIDTH           = 8,
    parameter logic [WIDTH-1:0]      POLY            = 8'h1B,
    parameter int unsigned           STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic             busy
);

    localparam int unsigned N  = WIDTH / STEPS_PER_CYCLE;
    localparam int unsigned CW = $clog2(N + 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("gf_mul_iter: WIDTH must be at least 2");
    end
    if (STEPS_PER_CYCLE == 0 || (WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
        $error("gf_mul_iter: STEPS_PER_CYCLE must divide WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_r_q, a_r_d;
    logic [WIDTH-1:0] b_r_q, b_r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] acc_step, a_step, b_step;

    // Unrolled steps: each one accumulates, then xtimes a_r and consumes one bit of b_r.
    always_comb begin
        acc_step = acc_q;
        a_step   = a_r_q;
        b_step   = b_r_q;
        for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
            if (b_step[0]) begin
                acc_step = acc_step ^ a_step;
            end
            if (a_step[WIDTH-1]) begin
                a_step = (a_step << 1) ^ POLY;
            end else begin
                a_step = a_step << 1;
            end
            b_step = b_step >> 1;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        a_r_d       = a_r_q;
        b_r_d       = b_r_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_r_d      = a;
                    b_r_d      = b;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                a_r_d = a_step;
                b_r_d = b_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    p_d         = acc_step;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            a_r_q       <= '0;
            b_r_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_r_q       <= a_r_d;
            b_r_q       <= b_r_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = p_q;

endmodule

// File: tb/tb_gf_mul_iter.sv
// Directed bench for gf_mul_iter: three configurations (W8/S1, W8/S2, W4/S1)
// checked against hand-computed GF products, latency, backpressure and reset.
module tb_gf_mul_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;

    logic iv1 = 1'b0, or1 = 1'b0, ir1, ov1, busy1;
    logic [7:0] p1;
    logic iv2 = 1'b0, or2 = 1'b0, ir2, ov2, busy2;
    logic [7:0] p2;
    logic iv4 = 1'b0, or4 = 1'b0, ir4, ov4, busy4;
    logic [3:0] p4;

    int checks = 0;
    int errors = 0;

    gf_mul_iter #(.WIDTH(8), .POLY(8'h1B), .STEPS_PER_CYCLE(1)) u_w8s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a8), .b(b8),
        .out_valid(ov1), .out_ready(or1), .p(p1), .busy(busy1));

    gf_mul_iter #(.WIDTH(8), .POLY(8'h1B), .STEPS_PER_CYCLE(2)) u_w8s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a8), .b(b8),
        .out_valid(ov2), .out_ready(or2), .p(p2), .busy(busy2));

    gf_mul_iter #(.WIDTH(4), .POLY(4'h3), .STEPS_PER_CYCLE(1)) u_w4s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_ov(input int sel);
        return (sel == 0) ? ov1 : (sel == 1) ? ov2 : ov4;
    endfunction
    function automatic logic cur_ir(input int sel);
        return (sel == 0) ? ir1 : (sel == 1) ? ir2 : ir4;
    endfunction
    function automatic logic cur_busy(input int sel);
        return (sel == 0) ? busy1 : (sel == 1) ? busy2 : busy4;
    endfunction
    function automatic logic [7:0] cur_p(input int sel);
        return (sel == 0) ? p1 : (sel == 1) ? p2 : {4'h0, p4};
    endfunction

    task automatic set_iv(input int sel, input logic v);
        if (sel == 0) iv1 = v; else if (sel == 1) iv2 = v; else iv4 = v;
    endtask
    task automatic set_or(input int sel, input logic v);
        if (sel == 0) or1 = v; else if (sel == 1) or2 = v; else or4 = v;
    endtask

    // Issue one op; returns after the product appeared (or the bound expired).
    task automatic start_and_wait(input int sel, input logic [7:0] av, input logic [7:0] bv,
                                  input logic [7:0] exp, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        a8 = av; b8 = bv; a4 = av[3:0]; b4 = bv[3:0];
        chk({tag, "_in_ready"}, 32'(cur_ir(sel)), 32'd1);
        set_iv(sel, 1'b1);
        @(posedge clk); #1;
        set_iv(sel, 1'b0);
        chk({tag, "_busy"}, 32'(cur_busy(sel)), 32'd1);
        lat = 0;
        while (!cur_ov(sel) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_p"}, 32'(cur_p(sel)), 32'(exp));
    endtask

    task automatic drain(input int sel, input logic [7:0] exp, input string tag);
        @(negedge clk);
        set_or(sel, 1'b1);
        @(posedge clk); #1;
        set_or(sel, 1'b0);
        chk({tag, "_drain_ov"}, 32'(cur_ov(sel)), 32'd0);
        chk({tag, "_drain_ir"}, 32'(cur_ir(sel)), 32'd1);
        chk({tag, "_drain_p"}, 32'(cur_p(sel)), 32'(exp));
    endtask

    task automatic op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] exp, input int exp_lat, input string tag);
        start_and_wait(sel, av, bv, exp, exp_lat, tag);
        drain(sel, exp, tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p1", 32'(p1), 32'd0);
        chk("rst_ov1", 32'(ov1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_ov2", 32'(ov2), 32'd0);
        chk("rst_p4", 32'(p4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ir1", 32'(ir1), 32'd1);
        chk("rst_ir2", 32'(ir2), 32'd1);
        chk("rst_ir4", 32'(ir4), 32'd1);

        // FIPS-197 products and xtime chain
        op(0, 8'h57, 8'h83, 8'hC1, 8, "w8s1_57x83");
        op(0, 8'h57, 8'h02, 8'hAE, 8, "w8s1_57x02");
        op(0, 8'h57, 8'h04, 8'h47, 8, "w8s1_57x04");
        op(0, 8'h57, 8'h08, 8'h8E, 8, "w8s1_57x08");
        op(0, 8'h57, 8'h10, 8'h07, 8, "w8s1_57x10");

        op(1, 8'h57, 8'h13, 8'hFE, 4, "w8s2_57x13");
        op(1, 8'h00, 8'hFF, 8'h00, 4, "w8s2_00xFF");

        op(2, 8'h08, 8'h02, 8'h03, 4, "w4_8x2");
        op(2, 8'h0F, 8'h01, 8'h0F, 4, "w4_Fx1");

        // Backpressure: product held, new operands ignored
        start_and_wait(0, 8'h57, 8'h83, 8'hC1, 8, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a8 = 8'h01; b8 = 8'h01;
            iv1 = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp_p_stable", 32'(p1), 32'hC1);
            chk("bp_ov_held", 32'(ov1), 32'd1);
            chk("bp_ir_low", 32'(ir1), 32'd0);
        end
        @(negedge clk);
        iv1 = 1'b0;
        drain(0, 8'hC1, "bp");
        op(0, 8'h02, 8'h03, 8'h06, 8, "bp_next_02x03");

        // Asynchronous reset mid-operation
        @(negedge clk);
        a8 = 8'h57; b8 = 8'h83; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(ov1), 32'd0);
        chk("arst_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ir", 32'(ir1), 32'd1);
        chk("arst_p", 32'(p1), 32'd0);
        op(0, 8'h57, 8'h83, 8'hC1, 8, "arst_next_57x83");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
